// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and a single-port memory.
// The arbiter takes the slave view; the environment (core + memory) takes the master view.
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    // Data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // Memory side
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory with a one-cycle read latency.
// Data wins by default; a pending fetch is forced through after MAX_D_STREAK data grants.
module mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);
    localparam logic PortI = 1'b0;
    localparam logic PortD = 1'b1;

    logic [StreakW-1:0] d_streak_q, d_streak_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_port_q, rsp_port_d;
    logic               rsp_err_q, rsp_err_d;

    logic i_gnt, d_gnt, d_sel, i_misaligned, d_store_empty;

    // Byte-offset bits of the data address carry no meaning for a word memory.
    logic unused_d_addr_lsb;
    assign unused_d_addr_lsb = ^bus.d_addr[1:0];

    // Grant selection; grants are also held off while reset is asserted.
    always_comb begin
        i_misaligned  = bus.i_addr[1:0] != 2'b00;
        d_store_empty = bus.d_we && (bus.d_be == 4'b0000);
        d_sel         = bus.d_req && !(bus.i_req && (d_streak_q == StreakMax));
        d_gnt         = rst_n && bus.m_ready && d_sel;
        i_gnt         = rst_n && bus.m_ready && !d_sel && bus.i_req;
        bus.d_gnt     = d_gnt;
        bus.i_gnt     = i_gnt;
    end

    // Memory strobe and payload come straight from whichever port is granted.
    always_comb begin
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_be    = 4'b0000;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (d_gnt) begin
            // A store with no enabled lanes is accepted but never touches memory.
            bus.m_en    = !d_store_empty;
            bus.m_we    = bus.d_we;
            bus.m_be    = bus.d_we ? bus.d_be : 4'b1111;
            bus.m_addr  = bus.d_addr[31:2];
            bus.m_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            // Misaligned fetches are accepted and answered with an error, no access.
            bus.m_en    = !i_misaligned;
            bus.m_be    = 4'b1111;
            bus.m_addr  = bus.i_addr[31:2];
        end
    end

    // Data streak counts data grants that jumped ahead of a waiting fetch.
    always_comb begin
        d_streak_d = d_streak_q;
        if (!bus.i_req || i_gnt) begin
            d_streak_d = '0;
        end else if (d_gnt && (d_streak_q != StreakMax)) begin
            d_streak_d = d_streak_q + 1'b1;
        end
    end

    // Response tracker: remembers which port owns next cycle's read data.
    always_comb begin
        rsp_valid_d = i_gnt || (d_gnt && !bus.d_we);
        rsp_port_d  = d_gnt ? PortD : PortI;
        rsp_err_d   = i_gnt && i_misaligned;
    end

    // Response outputs decoded from the tracker; a fetch error returns zero data.
    always_comb begin
        bus.i_rvalid = rsp_valid_q && (rsp_port_q == PortI);
        bus.i_err    = rsp_valid_q && (rsp_port_q == PortI) && rsp_err_q;
        bus.i_rdata  = rsp_err_q ? 32'h0 : bus.m_rdata;
        bus.d_rvalid = rsp_valid_q && (rsp_port_q == PortD);
        bus.d_rdata  = bus.m_rdata;
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_streak_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= PortI;
            rsp_err_q   <= 1'b0;
        end else begin
            d_streak_q  <= d_streak_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model (streak count, word array, one expected response).
module tb_mem_arbiter;

    localparam int MaxD = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_D_STREAK(MaxD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0000_0013 : ((32'h1111_1111 * 32'(i)) ^ 32'h5A00_00C3);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory device: 16-word window, one-cycle read latency, contents revert on reset.
    logic [31:0] ram [16];
    logic [15:0] ram_wr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr <= '0;
        end else if (bus.m_en) begin
            if (bus.m_we) begin
                ram[bus.m_addr[3:0]] <= merge(ram_wr[bus.m_addr[3:0]] ? ram[bus.m_addr[3:0]]
                                              : init_word(int'(bus.m_addr[3:0])),
                                              bus.m_wdata, bus.m_be);
                ram_wr[bus.m_addr[3:0]] <= 1'b1;
            end else begin
                bus.m_rdata <= ram_wr[bus.m_addr[3:0]] ? ram[bus.m_addr[3:0]]
                               : init_word(int'(bus.m_addr[3:0]));
            end
        end
    end

    // Reference model state
    int          streak;
    logic [31:0] mmem [16];
    logic        last_ig, last_dg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        streak = 0;
        for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] be,
                         input logic rdy);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_be    = be;
        bus.m_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    // One clock: check grant-cycle outputs, advance the model, check the response.
    task automatic tick();
        logic        dsel, eig, edg, mis, eme, nv, nport, nerr;
        logic [3:0]  ebe;
        logic [29:0] ea;
        logic [31:0] ndata;
        #1;
        dsel = bus.d_req && !(bus.i_req && streak == MaxD);
        edg  = bus.m_ready && dsel;
        eig  = bus.m_ready && !dsel && bus.i_req;
        mis  = bus.i_addr[1:0] != 2'b00;
        chk("i_gnt", 32'(bus.i_gnt), 32'(eig));
        chk("d_gnt", 32'(bus.d_gnt), 32'(edg));
        eme = 1'b0; ebe = 4'hf; ea = '0;
        if (edg) begin
            eme = !(bus.d_we && bus.d_be == 4'h0);
            ebe = bus.d_we ? bus.d_be : 4'hf;
            ea  = bus.d_addr[31:2];
        end else if (eig) begin
            eme = !mis;
            ea  = bus.i_addr[31:2];
        end
        chk("m_en", 32'(bus.m_en), 32'(eme));
        chk("m_we", 32'(bus.m_we), 32'(edg && bus.d_we));
        if (eme) begin
            chk("m_be", 32'(bus.m_be), 32'(ebe));
            chk("m_addr", 32'(bus.m_addr), 32'(ea));
            if (bus.d_we && edg) chk("m_wdata", bus.m_wdata, bus.d_wdata);
        end
        nv = 1'b0; nport = 1'b0; nerr = 1'b0; ndata = 32'h0;
        if (eig) begin
            nv = 1'b1; nerr = mis;
            ndata = mis ? 32'h0 : mmem[bus.i_addr[5:2]];
        end else if (edg && !bus.d_we) begin
            nv = 1'b1; nport = 1'b1;
            ndata = mmem[bus.d_addr[5:2]];
        end else if (edg && bus.d_be != 4'h0) begin
            mmem[bus.d_addr[5:2]] = merge(mmem[bus.d_addr[5:2]], bus.d_wdata, bus.d_be);
        end
        if (!bus.i_req || eig) streak = 0;
        else if (edg && streak < MaxD) streak++;
        last_ig = eig;
        last_dg = edg;
        @(posedge clk);
        #1;
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(nv && !nport));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(nv && nport));
        if (nv && !nport) begin
            chk("i_rdata", bus.i_rdata, ndata);
            chk("i_err", 32'(bus.i_err), 32'(nerr));
        end
        if (nv && nport) chk("d_rdata", bus.d_rdata, ndata);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_gnt"}, 32'(bus.i_gnt), 32'h0);
        chk({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'h0);
        chk({tag, "_i_rvalid"}, 32'(bus.i_rvalid), 32'h0);
        chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'h0);
        chk({tag, "_i_err"}, 32'(bus.i_err), 32'h0);
        chk({tag, "_m_en"}, 32'(bus.m_en), 32'h0);
        chk({tag, "_m_we"}, 32'(bus.m_we), 32'h0);
    endtask

    logic        ip, dp, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    string       seq;

    initial begin
        // Reset with requests pending: nothing may be granted.
        rst_n = 1'b0;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h104, 32'h0, 4'hf, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        tick();

        // Aligned fetch of word 0x40
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();
        chk("fetch_rdata", bus.i_rdata, 32'h0000_0013);
        chk("fetch_err", 32'(bus.i_err), 32'h0);

        // Both ports saturated: fetch forced through every MAX_D_STREAK data grants
        @(negedge clk);
        idle();
        tick();
        seq = "";
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1'b1, 32'h108, 1'b1, 1'b0, 32'h1004, 32'h0, 4'hf, 1'b1);
            tick();
            seq = {seq, last_dg ? "D" : (last_ig ? "I" : "-")};
        end
        n_tests++;
        assert (seq == "DDDDIDDDDI")
        else begin
            n_fail++;
            $error("FAIL grant_order got=%s exp=DDDDIDDDDI", seq);
        end

        // Single-lane store, unaligned byte address
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h203, 32'hAB00_0000, 4'b1000, 1'b1);
        #1;
        chk("store_m_addr", 32'(bus.m_addr), 32'h80);
        chk("store_m_be", 32'(bus.m_be), 32'h8);
        tick();
        chk("store_no_rvalid", 32'(bus.d_rvalid), 32'h0);

        // Store with no lanes enabled: accepted, no access, no response
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        tick();

        // Read back the word touched by the byte store
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b1);
        tick();
        chk("store_readback", bus.d_rdata, 32'hAB00_0013);

        // Misaligned fetch
        @(negedge clk);
        drive(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();
        chk("misaligned_err", 32'(bus.i_err), 32'h1);
        chk("misaligned_rdata", bus.i_rdata, 32'h0);

        // Memory stalled for three cycles, then data wins
        @(negedge clk);
        idle();
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 32'h10C, 1'b1, 1'b0, 32'h100C, 32'h0, 4'hf, 1'b0);
            tick();
        end
        @(negedge clk);
        drive(1'b1, 32'h10C, 1'b1, 1'b0, 32'h100C, 32'h0, 4'hf, 1'b1);
        tick();
        chk("stall_then_d", 32'(last_dg), 32'h1);

        // Reset asserted after a load grant drops the response
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h1010, 32'h0, 4'hf, 1'b1);
        #1;
        chk("pre_reset_d_gnt", 32'(bus.d_gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        chk("post_reset_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("post_reset_i_rvalid", 32'(bus.i_rvalid), 32'h0);

        // First cycle after reset arbitrates normally
        @(negedge clk);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();

        // Randomized traffic: requests held until granted
        ip = 1'b0;
        dp = 1'b0;
        ia = 32'h0; da = 32'h0; dwd = 32'h0; dbe = 4'h0; dwe = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (last_ig) ip = 1'b0;
            if (last_dg) dp = 1'b0;
            if (!ip && ($urandom % 3 != 0)) begin
                ip = 1'b1;
                ia = 32'h1000 + 32'($urandom % 16) * 4;
                if ($urandom % 8 == 0) ia[1:0] = 2'($urandom % 4);
            end
            if (!dp && ($urandom % 3 != 0)) begin
                dp  = 1'b1;
                dwe = 1'($urandom % 2);
                da  = 32'h2000 + 32'($urandom % 64);
                dwd = $urandom;
                dbe = ($urandom % 6 == 0) ? 4'h0 : 4'($urandom);
            end
            drive(ip, ia, dp, dwe, da, dwd, dbe, 1'($urandom % 4 != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
